// File: rtl/fpga_bird_pkg.sv
// Shared definitions for the game-sound blocks: note half-periods at 50 MHz,
// chime source codes, arbiter state encoding and the per-source note sequences.
package fpga_bird_pkg;

  localparam int unsigned G4_HALF = 32'd63775;  // 392 Hz
  localparam int unsigned C5_HALF = 32'd47801;  // 523 Hz

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PLAY1 = 2'd1,
    PLAY2 = 2'd2,
    GAP   = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    SRC_NONE  = 2'd0,
    SRC_START = 2'd1,
    SRC_SCORE = 2'd2,
    SRC_LOSE  = 2'd3
  } src_t;

  typedef enum logic {
    NOTE_G4 = 1'b0,
    NOTE_C5 = 1'b1
  } note_t;

  // start = C5; score = G4, C5; lose = C5, G4
  function automatic note_t first_note(input src_t src);
    return (src == SRC_SCORE) ? NOTE_G4 : NOTE_C5;
  endfunction

  function automatic note_t second_note(input src_t src);
    return (src == SRC_LOSE) ? NOTE_G4 : NOTE_C5;
  endfunction

  function automatic logic is_two_note(input src_t src);
    return (src == SRC_SCORE) || (src == SRC_LOSE);
  endfunction

endpackage

// File: rtl/tone_gen.sv
// Square-wave generator: counts half_period cycles per phase and toggles.
// restart forces the counter and phase back to 0 so every note begins low.
module tone_gen (
  input  logic        clk,
  input  logic        rst,
  input  logic        restart,
  input  logic [31:0] half_period,
  output logic        phase
);

  logic [31:0] cnt_q, cnt_d;
  logic        phase_q, phase_d;

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    cnt_d   = cnt_q + 32'd1;
    phase_d = phase_q;
    if (restart) begin
      cnt_d   = '0;
      phase_d = 1'b0;
    end else if (cnt_q >= half_period - 32'd1) begin
      cnt_d   = '0;
      phase_d = ~phase_q;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update
  // together from values sampled at the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  assign phase = phase_q;

endmodule

// File: rtl/tone_arbiter.sv
// Buzzer arbiter: latches chime requests, plays them one at a time by fixed
// priority (lose > start > score), and lets lose preempt any other chime.
module tone_arbiter
  import fpga_bird_pkg::*;
#(
  parameter int unsigned TICK_CYCLES    = 50000,
  parameter int unsigned NOTE_MS        = 125,
  parameter int unsigned GAP_MS         = 30,
  parameter int unsigned G4_HALF_CYCLES = G4_HALF,
  parameter int unsigned C5_HALF_CYCLES = C5_HALF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_req,
  input  logic       score_req,
  input  logic       lose_req,
  input  logic       mute,
  output logic       buzzer,
  output logic       busy,
  output logic [1:0] active_src
);

  // Pending flags, bit order {lose, score, start}
  logic [2:0]  pend_q, pend_d;
  logic [2:0]  req_v, eff, grant;
  state_t      state_q, state_d;
  src_t        src_q, src_d;
  logic [31:0] presc_q, presc_d;
  logic [31:0] ms_q, ms_d;
  logic [31:0] dur;
  logic [31:0] half_period;
  logic        tick, done, enter, playing, phase;
  note_t       cur_note;

  assign req_v   = {lose_req, score_req, start_req};
  assign eff     = pend_q | req_v;
  assign tick    = (presc_q == 32'(TICK_CYCLES - 1));
  assign dur     = (state_q == GAP) ? 32'(GAP_MS) : 32'(NOTE_MS);
  assign done    = tick && (ms_q == dur - 32'd1);
  assign playing = (state_q == PLAY1) || (state_q == PLAY2);

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    grant   = '0;
    unique case (state_q)
      IDLE: begin
        if (eff[2]) begin
          grant = 3'b100;
          src_d = SRC_LOSE;
        end else if (eff[0]) begin
          grant = 3'b001;
          src_d = SRC_START;
        end else if (eff[1]) begin
          grant = 3'b010;
          src_d = SRC_SCORE;
        end
        if (|eff) state_d = PLAY1;
      end
      PLAY1: if (done) state_d = is_two_note(src_q) ? PLAY2 : GAP;
      PLAY2: if (done) state_d = GAP;
      GAP: begin
        if (done) begin
          state_d = IDLE;
          src_d   = SRC_NONE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Lose aborts any other chime at once; the aborted source is simply dropped.
    if (state_q != IDLE && src_q != SRC_LOSE && eff[2]) begin
      grant   = 3'b100;
      src_d   = SRC_LOSE;
      state_d = PLAY1;
    end

    enter = (state_d != state_q) || (|grant);

    // A request that itself caused the grant is consumed; a fresh request for
    // a flag that was already pending re-arms it.
    pend_d = (pend_q & ~grant) | (req_v & ~(grant & ~pend_q));

    // Duration timer restarts on every state entry and idles at zero.
    presc_d = presc_q + 32'd1;
    ms_d    = ms_q;
    if (enter || state_q == IDLE) begin
      presc_d = '0;
      ms_d    = '0;
    end else if (tick) begin
      presc_d = '0;
      ms_d    = ms_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      src_q   <= SRC_NONE;
      pend_q  <= '0;
      presc_q <= '0;
      ms_q    <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      pend_q  <= pend_d;
      presc_q <= presc_d;
      ms_q    <= ms_d;
    end
  end

  assign cur_note    = (state_q == PLAY2) ? second_note(src_q) : first_note(src_q);
  assign half_period = (cur_note == NOTE_G4) ? 32'(G4_HALF_CYCLES) : 32'(C5_HALF_CYCLES);

  tone_gen u_tone_gen (
    .clk         (clk),
    .rst         (rst),
    .restart     (enter || !playing),
    .half_period (half_period),
    .phase       (phase)
  );

  assign buzzer     = playing && phase && !mute;
  assign busy       = (state_q != IDLE);
  assign active_src = src_q;

endmodule

// File: doc/tone_arbiter.md
TONE_ARBITER -- requirements
Module: tone_arbiter

Interface
REQ-001 SHALL have parameter TICK_CYCLES, default 50000, meaning clk cycles per 1 ms duration tick.
REQ-002 SHALL have parameter NOTE_MS, default 125, meaning duration of each note in ticks.
REQ-003 SHALL have parameter GAP_MS, default 30, meaning silent gap after each sequence in ticks.
REQ-004 SHALL have port clk, input, 1, the single clock (50 MHz).
REQ-005 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-006 SHALL have port start_req, input, 1, one-cycle pulse requesting the start chime.
REQ-007 SHALL have port score_req, input, 1, one-cycle pulse requesting the score chime.
REQ-008 SHALL have port lose_req, input, 1, one-cycle pulse requesting the lose tone.
REQ-009 SHALL have port mute, input, 1, level; forces buzzer low without altering sequencing.
REQ-010 SHALL have port buzzer, output, 1, square wave to the passive buzzer pin.
REQ-011 SHALL have port busy, output, 1, high in any state other than IDLE.
REQ-012 SHALL have port active_src, output, 2, 0 none / 1 start / 2 score / 3 lose.

Function
REQ-013 SHALL latch each request pulse into its own pending flag; repeated pulses while pending coalesce to one.
REQ-014 SHALL use FSM states IDLE, PLAY1, PLAY2, GAP.
REQ-015 SHALL, in IDLE with any flag pending, grant by fixed priority lose > start > score, clear that flag and enter PLAY1 the next cycle.
REQ-016 SHALL use sequences: start = C5 only; score = G4 then C5; lose = C5 then G4.
REQ-017 SHALL hold each note NOTE_MS ticks, then go PLAY1->PLAY2 (two-note) or PLAY1->GAP (one-note), PLAY2->GAP.
REQ-018 SHALL stay silent in GAP for GAP_MS ticks, then return to IDLE.
REQ-019 SHALL, on lose_req while playing score or start, preempt: abort within 1 cycle, clear lose flag, restart PLAY1 with lose; the aborted sequence is dropped, not requeued.
REQ-020 SHALL NOT preempt for start_req or score_req; they wait pending.
REQ-021 SHALL generate notes by half-period counting: G4 = 63775 cycles, C5 = 47801 cycles; counter and buzzer phase reset to 0 at each note start.
REQ-022 SHALL drive buzzer = tone phase AND NOT mute in PLAY1/PLAY2, else 0.
REQ-023 SHALL restart the 1 ms tick prescaler at every state entry so durations are exact to +/-1 cycle.
REQ-024 SHALL hold active_src at the granted source from PLAY1 through GAP, 0 in IDLE.
REQ-025 SHALL accept a request arriving on the same cycle as grant/clear of its own flag (flag re-set wins).
REQ-026 SHALL size all counters 32 bits with no wrap reachable under default parameters.

Reset
REQ-027 SHALL, on rst high at a clk edge, enter IDLE, clear all pending flags, counters and tone phase; buzzer=0, busy=0, active_src=0 from the next cycle.
REQ-028 SHALL apply REQ-027 mid-sequence with no residual tone.
REQ-029 SHALL ignore request pulses on cycles where rst is high.

Structure
REQ-030 SHALL take note half-period constants, source codes and state encoding from shared package fpga_bird_pkg.
REQ-031 SHALL instantiate one sub-module tone_gen (half-period counter plus phase toggle, inputs half_period and restart).

Verification (sim with TICK_CYCLES=10, NOTE_MS=4, GAP_MS=2; half-periods G4=7, C5=5 overridden)
REQ-032 SHALL cover: score_req pulse -> busy next cycle, active_src=2, G4 toggling every 7 cycles for 40 cycles, then C5 every 5 for 40, 20 silent, IDLE.
REQ-033 SHALL cover: start_req, score_req, lose_req same cycle -> lose played first, then start, then score, each separated by a GAP.
REQ-034 SHALL cover: lose_req at cycle 15 of a score sequence -> active_src=3 within 1 cycle, C5 restarts at phase 0, score never resumes.
REQ-035 SHALL cover: three score_req pulses during a lose sequence -> exactly one score sequence afterwards.
REQ-036 SHALL cover: mute=1 throughout a score sequence -> buzzer constantly 0, busy and timing identical to unmuted.
REQ-037 SHALL cover: rst asserted in PLAY2 -> next cycle buzzer=0, busy=0, active_src=0, no playback after rst deasserts without new requests.
